cpu_ctrl: RTL and testbench
===========================

Name: cpu_ctrl

Overview:
- Control unit for the one-cycle CPU: program counter, instruction decoder and return-address stack.
- Fetches one instruction per clock from combinational program memory and decodes it into the cpu_data control inputs.
- Samples the datapath zero flag for conditional jumps.
- Sits between program memory and cpu_data; drives every cpu_data control input.

Parameters:
- WIDTH, 8: data/operand width; equals the PC width.
- IWIDTH, 4: ALU operation code width.
- OP_WIDTH, 5: opcode width.
- REG_F_SEL_SIZE, 4: register-file select width.
- IN_B_SEL_SIZE, 2: ALU B-input select width.
- STACK_DEPTH, 4: return-stack entries.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- pc_rst_n  in  1  asynchronous, active-low reset.
- instr  in  OP_WIDTH+WIDTH  instruction. [12:8] is the opcode; [7:0] is the operand.
- start  in  1  resume from HALT.
- flag_z_out  in  1  zero flag from cpu_data.
- pc  out  WIDTH  program memory address.
- reg_f_sel  out  REG_F_SEL_SIZE  equals operand[3:0].
- en_reg_f  out  1  register-file write enable.
- d_mem_addr  out  WIDTH  equals operand.
- d_mem_addr_mode  out  1  0: address from operand; 1: address from register.
- en_d_mem  out  1  data memory write enable.
- in_b_sel  out  IN_B_SEL_SIZE  00: immediate; 01: register file; 10: data memory.
- imm  out  WIDTH  equals operand.
- alu_out  out  IWIDTH  ALU operation; 4'hF = pass B.
- en_acc  out  1  accumulator write enable.
- halted  out  1  high in HALT.
- trap  out  1  high in TRAP (only with CTRL_TRAP_EN).

Behaviour:
- Reset (pc_rst_n low, asynchronous):
  - pc=0, stack pointer sp=0, state=RUN.
  - All enables 0, halted=0, trap=0.
  - Enables are held 0 while reset is asserted, whatever instr is.
- Defaults for any instruction: all enables 0, in_b_sel=00, alu_out=4'hF, d_mem_addr_mode=0. reg_f_sel, d_mem_addr and imm always follow the operand fields.
- Outputs decode combinationally from instr in RUN. In HALT and TRAP all enables are 0 and pc holds.
- Sequencing: pc<=pc+1 unless stated otherwise. pc wraps 8'hFF→8'h00.
- Opcodes:
  - 00 NOP.
  - 01 LDI: in_b_sel=00, en_acc=1.
  - 02 LDR: in_b_sel=01, en_acc=1.
  - 03 LD: in_b_sel=10, en_acc=1.
  - 04 LDX: as LD but d_mem_addr_mode=1.
  - 05 STR: en_reg_f=1.
  - 06 ST: en_d_mem=1.
  - 07 STX: en_d_mem=1, d_mem_addr_mode=1.
  - 08 JMP: pc<=operand.
  - 09 JZ: pc<=operand if flag_z_out=1, else pc+1.
  - 0A JNZ: opposite condition to JZ.
  - 0B CALL: push pc+1, sp++, pc<=operand.
  - 0C RET: sp--, pc<=popped value.
  - 0D HLT: state<=HALT; pc holds at the HLT address.
  - 10–1F ALU: alu_out=opcode[3:0], in_b_sel=10, en_acc=1.
  - 0E, 0F: illegal.
- flag_z_out is sampled in the same cycle as the jump. The decision uses the flag value present before that edge.
- States: RUN, HALT, TRAP.
  - HALT→RUN when start=1 at the edge; pc<=pc+1.
  - start is ignored in RUN.
  - TRAP is left only by reset.
- Stack boundaries:
  - CALL with sp==STACK_DEPTH is an overflow.
  - RET with sp==0 is an underflow.
  - CALL with sp==STACK_DEPTH-1 is legal and fills the stack.

Optional Feature:
- Macro: CTRL_TRAP_EN.
- Defined:
  - Overflow, underflow or an illegal opcode sends the state machine to TRAP.
  - pc freezes at the faulting address and trap=1 from the next cycle.
  - The faulting instruction has no effect: no push, no jump, no enables.
- Undefined:
  - Overflow CALL jumps but does not push.
  - Underflow RET behaves as NOP (pc+1).
  - Illegal opcodes behave as NOP.
  - trap is tied 0.

Test Plan:
1. Reset, then instr=01_69 → pc=00, en_acc=1, in_b_sel=00, imm=69, alu_out=F; pc=01 after the edge. Assert pc_rst_n low mid-run → pc=00 and enables 0 immediately, without waiting for a clock edge.
2. Decode of each remaining load/store opcode with operand 03 → enables match the opcode list; STX/LDX give d_mem_addr_mode=1; 15_00 → alu_out=5, in_b_sel=10.
3. JZ 40 with flag_z_out=1 → pc=40; with flag_z_out=0 → pc+1; JNZ mirrored. JMP from pc=FF with NOP → pc=00.
4. CALL 20 at pc=10, then RET → pc=20, then 11. Four nested CALLs then four RETs unwind correctly. A fifth CALL → jumps without pushing (macro off) / trap=1, pc frozen (macro on).
5. RET with empty stack at pc=30 → pc=31 (macro off) / TRAP (macro on). Opcode 0E → NOP / TRAP.
6. HLT at pc=05 → halted=1, pc stays 05, enables 0 over 3 cycles; start=1 → pc=06, halted=0.

Source files
------------

// File: rtl/cpu_ctrl.sv
// Control unit for the one-cycle CPU: PC, decoder and return-address stack.
// Optional CTRL_TRAP_EN: stack over/underflow and illegal opcodes enter a sticky TRAP state.
module cpu_ctrl #(
  parameter int WIDTH          = 8,
  parameter int IWIDTH         = 4,
  parameter int OP_WIDTH       = 5,
  parameter int REG_F_SEL_SIZE = 4,
  parameter int IN_B_SEL_SIZE  = 2,
  parameter int STACK_DEPTH    = 4
) (
  input  logic                        clk,
  input  logic                        pc_rst_n,
  input  logic [OP_WIDTH+WIDTH-1:0]   instr,
  input  logic                        start,
  input  logic                        flag_z_out,
  output logic [WIDTH-1:0]            pc,
  output logic [REG_F_SEL_SIZE-1:0]   reg_f_sel,
  output logic                        en_reg_f,
  output logic [WIDTH-1:0]            d_mem_addr,
  output logic                        d_mem_addr_mode,
  output logic                        en_d_mem,
  output logic [IN_B_SEL_SIZE-1:0]    in_b_sel,
  output logic [WIDTH-1:0]            imm,
  output logic [IWIDTH-1:0]           alu_out,
  output logic                        en_acc,
  output logic                        halted,
  output logic                        trap
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

`ifdef CTRL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam logic [OP_WIDTH-1:0] OP_LDI  = OP_WIDTH'(8'h01);
  localparam logic [OP_WIDTH-1:0] OP_LDR  = OP_WIDTH'(8'h02);
  localparam logic [OP_WIDTH-1:0] OP_LD   = OP_WIDTH'(8'h03);
  localparam logic [OP_WIDTH-1:0] OP_LDX  = OP_WIDTH'(8'h04);
  localparam logic [OP_WIDTH-1:0] OP_STR  = OP_WIDTH'(8'h05);
  localparam logic [OP_WIDTH-1:0] OP_ST   = OP_WIDTH'(8'h06);
  localparam logic [OP_WIDTH-1:0] OP_STX  = OP_WIDTH'(8'h07);
  localparam logic [OP_WIDTH-1:0] OP_JMP  = OP_WIDTH'(8'h08);
  localparam logic [OP_WIDTH-1:0] OP_JZ   = OP_WIDTH'(8'h09);
  localparam logic [OP_WIDTH-1:0] OP_JNZ  = OP_WIDTH'(8'h0A);
  localparam logic [OP_WIDTH-1:0] OP_CALL = OP_WIDTH'(8'h0B);
  localparam logic [OP_WIDTH-1:0] OP_RET  = OP_WIDTH'(8'h0C);
  localparam logic [OP_WIDTH-1:0] OP_HLT  = OP_WIDTH'(8'h0D);

  localparam logic [IN_B_SEL_SIZE-1:0] B_IMM = IN_B_SEL_SIZE'(0);
  localparam logic [IN_B_SEL_SIZE-1:0] B_REG = IN_B_SEL_SIZE'(1);
  localparam logic [IN_B_SEL_SIZE-1:0] B_MEM = IN_B_SEL_SIZE'(2);

  typedef enum logic [1:0] {S_RUN, S_HALT, S_TRAP} state_t;

  state_t                  r_state, w_state_nxt;
  logic [WIDTH-1:0]        r_pc, w_pc_nxt, w_pc_inc;
  logic [SP_W-1:0]         r_sp;
  logic [WIDTH-1:0]        r_stack [STACK_DEPTH];
  logic [OP_WIDTH-1:0]     w_opcode;
  logic [WIDTH-1:0]        w_operand;
  logic [IDX_W-1:0]        w_top_idx;
  logic                    w_full, w_empty, w_exec;
  logic                    w_push, w_pop, w_fault;

  assign w_opcode  = instr[OP_WIDTH+WIDTH-1 -: OP_WIDTH];
  assign w_operand = instr[WIDTH-1:0];
  assign w_pc_inc  = r_pc + WIDTH'(1);
  assign w_full    = (r_sp == SP_W'(STACK_DEPTH));
  assign w_empty   = (r_sp == '0);
  assign w_top_idx = IDX_W'(r_sp - 1'b1);
  // Reset gates the decode directly so enables drop without waiting for an edge.
  assign w_exec    = pc_rst_n && (r_state == S_RUN);

  assign pc         = r_pc;
  assign reg_f_sel  = w_operand[REG_F_SEL_SIZE-1:0];
  assign d_mem_addr = w_operand;
  assign imm        = w_operand;
  assign halted     = (r_state == S_HALT);
`ifdef CTRL_TRAP_EN
  assign trap       = (r_state == S_TRAP);
`else
  assign trap       = 1'b0;
`endif

  // NOTE: every output gets a default before the case, so no path leaves a latch.
  always_comb begin
    en_reg_f        = 1'b0;
    en_d_mem        = 1'b0;
    en_acc          = 1'b0;
    in_b_sel        = B_IMM;
    alu_out         = '1;
    d_mem_addr_mode = 1'b0;
    if (w_exec) begin
      if (w_opcode[OP_WIDTH-1]) begin
        alu_out  = w_opcode[IWIDTH-1:0];
        in_b_sel = B_MEM;
        en_acc   = 1'b1;
      end else begin
        case (w_opcode)
          OP_LDI: en_acc = 1'b1;
          OP_LDR: begin in_b_sel = B_REG; en_acc = 1'b1; end
          OP_LD:  begin in_b_sel = B_MEM; en_acc = 1'b1; end
          OP_LDX: begin in_b_sel = B_MEM; en_acc = 1'b1; d_mem_addr_mode = 1'b1; end
          OP_STR: en_reg_f = 1'b1;
          OP_ST:  en_d_mem = 1'b1;
          OP_STX: begin en_d_mem = 1'b1; d_mem_addr_mode = 1'b1; end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = w_pc_inc;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_fault     = 1'b0;
    case (r_state)
      S_RUN: begin
        case (w_opcode)
          OP_JMP: w_pc_nxt = w_operand;
          OP_JZ:  if (flag_z_out)  w_pc_nxt = w_operand;
          OP_JNZ: if (!flag_z_out) w_pc_nxt = w_operand;
          OP_CALL: begin
            w_pc_nxt = w_operand;
            if (w_full) w_fault = 1'b1;
            else        w_push  = 1'b1;
          end
          OP_RET: begin
            if (w_empty) w_fault = 1'b1;
            else begin
              w_pop    = 1'b1;
              w_pc_nxt = r_stack[w_top_idx];
            end
          end
          OP_HLT: begin
            w_state_nxt = S_HALT;
            w_pc_nxt    = r_pc;
          end
          default: w_fault = !w_opcode[OP_WIDTH-1] && (w_opcode > OP_HLT);
        endcase
        // A trapping instruction must leave no trace: no push, no jump.
        if (TRAP_EN && w_fault) begin
          w_state_nxt = S_TRAP;
          w_pc_nxt    = r_pc;
          w_push      = 1'b0;
          w_pop       = 1'b0;
        end
      end
      S_HALT: begin
        if (start) w_state_nxt = S_RUN;
        else       w_pc_nxt    = r_pc;
      end
      default: w_pc_nxt = r_pc;
    endcase
  end

  always_ff @(posedge clk or negedge pc_rst_n) begin
    if (!pc_rst_n) begin
      r_state <= S_RUN;
      r_pc    <= '0;
      r_sp    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_push)     r_sp <= r_sp + 1'b1;
      else if (w_pop) r_sp <= r_sp - 1'b1;
    end
  end

  // NOTE: stack storage is not reset; sp alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_stack[IDX_W'(r_sp)] <= w_pc_inc;
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Scoreboard bench for cpu_ctrl: directed and random instructions against a queue-based model.
module tb_cpu_ctrl;

`ifdef CTRL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] pc;
    logic [3:0] rsel;
    logic       en_reg_f;
    logic [7:0] daddr;
    logic       mode;
    logic       en_d_mem;
    logic [1:0] bsel;
    logic [7:0] imm;
    logic [3:0] alu;
    logic       en_acc;
    logic       halted;
    logic       trap;
  } obs_t;

  logic        clk = 1'b0;
  logic        pc_rst_n = 1'b0;
  logic [12:0] instr = '0;
  logic        start = 1'b0;
  logic        flag_z_out = 1'b0;
  logic [7:0]  pc, d_mem_addr, imm;
  logic [3:0]  reg_f_sel, alu_out;
  logic [1:0]  in_b_sel;
  logic        en_reg_f, d_mem_addr_mode, en_d_mem, en_acc, halted, trap;

  cpu_ctrl dut (
    .clk(clk), .pc_rst_n(pc_rst_n), .instr(instr), .start(start), .flag_z_out(flag_z_out),
    .pc(pc), .reg_f_sel(reg_f_sel), .en_reg_f(en_reg_f), .d_mem_addr(d_mem_addr),
    .d_mem_addr_mode(d_mem_addr_mode), .en_d_mem(en_d_mem), .in_b_sel(in_b_sel),
    .imm(imm), .alu_out(alu_out), .en_acc(en_acc), .halted(halted), .trap(trap)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_cyc = 0;
  obs_t sb_q[$];

  // Reference model: architectural state only.
  int m_pc = 0;
  int m_stk[$];
  bit m_halt = 0;
  bit m_trap = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic obs_t model_out(input logic [12:0] ins);
    obs_t e;
    int   op;
    op = int'(ins[12:8]);
    e = '0;
    e.pc = m_pc[7:0];
    e.rsel = ins[3:0];
    e.daddr = ins[7:0];
    e.imm = ins[7:0];
    e.alu = 4'hF;
    e.halted = m_halt;
    e.trap = m_trap;
    if (!m_halt && !m_trap) begin
      if (op >= 16) begin
        e.alu = 4'(op - 16); e.bsel = 2'd2; e.en_acc = 1'b1;
      end else if (op == 1) e.en_acc = 1'b1;
      else if (op == 2) begin e.bsel = 2'd1; e.en_acc = 1'b1; end
      else if (op == 3) begin e.bsel = 2'd2; e.en_acc = 1'b1; end
      else if (op == 4) begin e.bsel = 2'd2; e.en_acc = 1'b1; e.mode = 1'b1; end
      else if (op == 5) e.en_reg_f = 1'b1;
      else if (op == 6) e.en_d_mem = 1'b1;
      else if (op == 7) begin e.en_d_mem = 1'b1; e.mode = 1'b1; end
    end
    return e;
  endfunction

  task automatic model_step(input logic [12:0] ins, input logic st, input logic fz);
    int op, opnd, nxt;
    bit fault;
    op = int'(ins[12:8]);
    opnd = int'(ins[7:0]);
    nxt = (m_pc + 1) % 256;
    fault = 0;
    if (m_trap) return;
    if (m_halt) begin
      if (st) begin m_halt = 0; m_pc = nxt; end
      return;
    end
    case (op)
      8:  nxt = opnd;
      9:  if (fz) nxt = opnd;
      10: if (!fz) nxt = opnd;
      11: begin
        if (m_stk.size() < 4) m_stk.push_back(nxt);
        else fault = 1;
        nxt = opnd;
      end
      12: if (m_stk.size() > 0) nxt = m_stk.pop_back(); else fault = 1;
      13: begin m_halt = 1; nxt = m_pc; end
      14, 15: fault = 1;
      default: ;
    endcase
    if (fault && TRAP_EN) begin
      m_trap = 1;
      nxt = m_pc;
    end
    m_pc = nxt;
  endtask

  // Called at posedge+1; leaves at the next posedge+1.
  task automatic cyc(input logic [12:0] ins, input logic st = 1'b0, input logic fz = 1'b0);
    instr = ins;
    start = st;
    flag_z_out = fz;
    sb_q.push_back(model_out(ins));
    model_step(ins, st, fz);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    instr = 13'h0169;
    #1 pc_rst_n = 1'b0;
    #1 check("rst_async", 64'({pc, en_reg_f, en_d_mem, en_acc, halted, trap}), 64'(13'h0000));
    m_pc = 0;
    m_stk.delete();
    m_halt = 0;
    m_trap = 0;
    @(posedge clk);
    #1 pc_rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    obs_t e, g;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      g = '{pc: pc, rsel: reg_f_sel, en_reg_f: en_reg_f, daddr: d_mem_addr,
            mode: d_mem_addr_mode, en_d_mem: en_d_mem, bsel: in_b_sel, imm: imm,
            alu: alu_out, en_acc: en_acc, halted: halted, trap: trap};
      check($sformatf("cyc%0d_pc%02h", n_cyc, e.pc), 64'(g), 64'(e));
      n_cyc++;
    end
  end

  initial begin
    logic [12:0] ins;
    int          r;
    repeat (2) @(posedge clk);
    #1 pc_rst_n = 1'b1;

    // Reset values, first fetch, start ignored in RUN, asynchronous reset mid-run.
    cyc(13'h0169);
    cyc(13'h0000);
    cyc(13'h0203, 1'b1);
    do_reset();

    // Load/store/ALU decode.
    for (int op = 2; op <= 7; op++) cyc({5'(op), 8'h03});
    cyc(13'h1500);
    cyc(13'h1AA5);
    cyc(13'h1F03);

    // Jumps, wrap, conditional jumps.
    cyc(13'h08FF);
    cyc(13'h0000);
    cyc(13'h0940, 1'b0, 1'b1);
    cyc(13'h0800);
    cyc(13'h0940, 1'b0, 1'b0);
    cyc(13'h0A40, 1'b0, 1'b0);
    cyc(13'h0A40, 1'b0, 1'b1);

    // CALL/RET, nesting, overflow, underflow.
    cyc(13'h0810);
    cyc(13'h0B20);
    cyc(13'h0C00);
    cyc(13'h0000);
    for (int i = 0; i < 4; i++) cyc({5'h0B, 8'(8'h50 + i * 16)});
    for (int i = 0; i < 4; i++) cyc(13'h0C00);
    for (int i = 0; i < 4; i++) cyc({5'h0B, 8'(8'h50 + i * 16)});
    cyc(13'h0B90);
    cyc(13'h0169);
    cyc(13'h0000);
    for (int i = 0; i < 5; i++) cyc(13'h0C00);
    do_reset();
    cyc(13'h0830);
    cyc(13'h0C00);
    cyc(13'h0000);
    do_reset();
    cyc(13'h0E00);
    cyc(13'h0301);
    cyc(13'h0F00);
    do_reset();

    // HALT and resume.
    cyc(13'h0805);
    cyc(13'h0D00);
    for (int i = 0; i < 3; i++) cyc(13'h0169);
    cyc(13'h0000, 1'b1);
    cyc(13'h0000);

    // Random instruction stream.
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 40)      ins = {5'($urandom_range(16, 31)), 8'($urandom)};
      else if (r < 97) ins = {5'($urandom_range(0, 13)), 8'($urandom)};
      else             ins = {5'($urandom_range(14, 15)), 8'($urandom)};
      cyc(ins, 1'($urandom_range(0, 3) == 0), 1'($urandom));
      if (m_trap && $urandom_range(0, 3) == 0) do_reset();
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
